pwm_timer: RTL and testbench

//  Motor PWM timer; the producer end of the TCR.E strobe that the 7-segment block consumes.
//  - Counts a fixed period and drives the two H-bridge PWM legs from a switch-selected duty and direction.
//  - Emits the one-cycle period strobe E, which also multiplexes the display.
//  - Latches an overcurrent fault from sense input SnsA.

---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_timer_sns_filter.sv | 25 ++
 rtl/pwm_timer.sv | 90 +++++++++
 tb/tb_pwm_timer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state encoding, duty limit and compare-width helper for the PWM timer.
package pwm_pkg;
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DEAD  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;
  localparam logic [6:0] DUTY_MAX = 7'd127;
  function automatic int cmp_w(input int cnt_w);
    return cnt_w + 1;
  endfunction
endpackage

// File: rtl/pwm_timer_sns_filter.sv
// sns_filter: 2-FF synchronizer plus saturating run-length counter for an async sense input.
module sns_filter #(
  parameter int FILT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sns,
  output logic o_sync,
  output logic o_fire
);
  localparam int FW = $clog2(FILT + 1);
  logic [1:0]    r_sync;
  logic [FW-1:0] r_cnt;
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_sync <= '0;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], i_sns};
      r_cnt  <= !r_sync[1] ? '0 : (r_cnt == FW'(FILT)) ? r_cnt : r_cnt + FW'(1);
    end
  assign o_sync = r_sync[1];
  // fires in the cycle the run length reaches FILT, so the fault lands on the same edge
  assign o_fire = r_sync[1] && (r_cnt >= FW'(FILT - 1));
endmodule

// File: rtl/pwm_timer.sv
// pwm_timer: H-bridge PWM with period strobe E, dead period on reversal and latched overcurrent fault.
// Define OC_AUTO_RETRY_EN to let FAULT recover after RETRY_PER clean periods.
module pwm_timer
  import pwm_pkg::*;
#(
  parameter int CNT_W     = 17,
  parameter int PERIOD    = 100000,
  parameter int STEP      = 781,
  parameter int OC_FILT   = 4,
  parameter int RETRY_PER = 8
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [6:0] DUTY,
  input  logic       SW7,
  input  logic       SnsA,
  output logic       PWM_A,
  output logic       PWM_B,
  output logic       E,
  output logic       OC
);
  localparam int CW = cmp_w(CNT_W);
  logic [CNT_W-1:0] r_cnt;
  logic [6:0]       r_duty;
  logic             r_dir, r_pwm_a, r_pwm_b;
  state_t           r_state, w_next;
  logic             w_sync, w_fire, w_lvl, w_retry_done;
  logic [CW-1:0]    w_cmp;
  sns_filter #(.FILT(OC_FILT)) u_sns (
    .clk   (CLK),
    .rst_n (RSTn),
    .i_sns (SnsA),
    .o_sync(w_sync),
    .o_fire(w_fire)
  );
  assign E     = r_cnt == CNT_W'(PERIOD - 1);
  assign OC    = r_state == ST_FAULT;
  assign PWM_A = r_pwm_a;
  assign PWM_B = r_pwm_b;
  assign w_cmp = CW'(r_duty) * CW'(STEP);
  assign w_lvl = (r_duty == DUTY_MAX) || ({1'b0, r_cnt} < w_cmp);
`ifdef OC_AUTO_RETRY_EN
  localparam int RW = $clog2(RETRY_PER + 1);
  logic          r_clean;
  logic [RW-1:0] r_retry;
  // r_clean: the period now ending began inside FAULT and has seen no synced sense
  assign w_retry_done = r_clean && !w_sync && (r_retry == RW'(RETRY_PER - 1));
  always_ff @(posedge CLK)
    if (!RSTn || r_state != ST_FAULT) begin
      r_clean <= 1'b0;
      r_retry <= '0;
    end else if (E) begin
      r_clean <= 1'b1;
      r_retry <= (r_clean && !w_sync && !w_retry_done) ? r_retry + RW'(1) : '0;
    end else if (w_sync) begin
      r_clean <= 1'b0;
    end
`else
  logic w_sync_unused;
  assign w_sync_unused = w_sync;
  assign w_retry_done  = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    if (E)
      w_next = (r_state == ST_RUN && SW7 != r_dir) ? ST_DEAD :
               (r_state == ST_DEAD) ? ST_RUN :
               (r_state == ST_FAULT && w_retry_done) ? ST_DEAD : r_state;
    if (w_fire)
      w_next = ST_FAULT;
  end
  always_ff @(posedge CLK)
    if (!RSTn) begin
      r_cnt   <= '0;
      r_duty  <= '0;
      r_dir   <= 1'b0;
      r_state <= ST_RUN;
      r_pwm_a <= 1'b0;
      r_pwm_b <= 1'b0;
    end else begin
      r_cnt   <= E ? '0 : r_cnt + CNT_W'(1);
      if (E) begin
        r_duty <= DUTY;
        r_dir  <= SW7;
      end
      r_state <= w_next;
      r_pwm_a <= !w_fire && r_state == ST_RUN && !r_dir && w_lvl;
      r_pwm_b <= !w_fire && r_state == ST_RUN && r_dir && w_lvl;
    end
endmodule

// File: tb/tb_pwm_timer.sv
// tb_pwm_timer: directed stimulus against a per-cycle behavioural model plus hand-computed duty counts.
module tb_pwm_timer;
  localparam int CNT_W = 8, PERIOD = 256, STEP = 2, OC_FILT = 4, RETRY_PER = 2;
  localparam int RUN = 0, DEAD = 1, FAULT = 2;
  logic clk = 1'b0, rstn = 1'b0, sw7 = 1'b0, sns = 1'b0;
  logic [6:0] duty = 7'd0;
  logic pwm_a, pwm_b, e, oc;
  int total = 0, bad = 0;
  pwm_timer #(
    .CNT_W(CNT_W), .PERIOD(PERIOD), .STEP(STEP), .OC_FILT(OC_FILT), .RETRY_PER(RETRY_PER)
  ) dut (
    .CLK(clk), .RSTn(rstn), .DUTY(duty), .SW7(sw7), .SnsA(sns),
    .PWM_A(pwm_a), .PWM_B(pwm_b), .E(e), .OC(oc)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model state: position in period, shadow duty/dir, operating mode, raw sense history
  int m_cnt = 0, m_duty = 0, m_dir = 0, m_mode = RUN, m_good = 0;
  bit m_dirty = 1'b1, ex_a = 1'b0, ex_b = 1'b0, started = 1'b0;
  bit sh [0:OC_FILT+1];
  always @(posedge clk) begin : model
    bit fire, sync, wrap, lvl;
    int nmode;
    if (!rstn) begin
      m_cnt = 0; m_duty = 0; m_dir = 0; m_mode = RUN; m_good = 0; m_dirty = 1'b1;
      ex_a = 1'b0; ex_b = 1'b0;
      for (int i = 0; i <= OC_FILT + 1; i++) sh[i] = 1'b0;
    end else begin
      for (int i = OC_FILT + 1; i > 0; i--) sh[i] = sh[i-1];
      sh[0] = sns;
      fire = 1'b1;
      for (int i = 2; i <= OC_FILT + 1; i++) fire &= sh[i];
      sync = sh[2];
      lvl  = (m_duty == 127) || (m_cnt < m_duty * STEP);
      ex_a = !fire && m_mode == RUN && m_dir == 0 && lvl;
      ex_b = !fire && m_mode == RUN && m_dir == 1 && lvl;
      wrap  = m_cnt == PERIOD - 1;
      nmode = m_mode;
      if (m_mode != FAULT) begin
        m_dirty = 1'b1;
        m_good  = 0;
      end
      if (wrap) begin
        if (m_mode == RUN && int'(sw7) != m_dir) nmode = DEAD;
        else if (m_mode == DEAD) nmode = RUN;
`ifdef OC_AUTO_RETRY_EN
        else if (m_mode == FAULT) begin
          m_good  = (!m_dirty && !sync) ? m_good + 1 : 0;
          m_dirty = 1'b0;
          if (m_good == RETRY_PER) begin
            nmode  = DEAD;
            m_good = 0;
          end
        end
`endif
        m_duty = int'(duty);
        m_dir  = int'(sw7);
        m_cnt  = 0;
      end else begin
        if (m_mode == FAULT && sync) m_dirty = 1'b1;
        m_cnt++;
      end
      if (fire) nmode = FAULT;
      m_mode = nmode;
    end
    started = 1'b1;
  end

  always @(negedge clk)
    if (started) begin
      chk("pwm_a", pwm_a, ex_a);
      chk("pwm_b", pwm_b, ex_b);
      chk("e", e, int'(m_cnt == PERIOD - 1));
      chk("oc", oc, int'(m_mode == FAULT));
      chk("legs_exclusive", pwm_a & pwm_b, 0);
    end

  task automatic wait_e();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!e && n < 2000);
    chk("e_seen", e, 1);
  endtask

  task automatic window(output int na, output int nb, output int ne,
                        input int at, input logic [6:0] nd, input logic nsw);
    na = 0; nb = 0; ne = 0;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      if (i == at) begin
        duty = nd;
        sw7  = nsw;
      end
      na += int'(pwm_a);
      nb += int'(pwm_b);
      ne += int'(e);
    end
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_pwm_a"}, pwm_a, 0);
    chk({tag, "_pwm_b"}, pwm_b, 0);
    chk({tag, "_e"}, e, 0);
    chk({tag, "_oc"}, oc, 0);
  endtask

  task automatic reset_pulse_and_check(input string tag);
    int n;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    zero_outputs(tag);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!e && n < 1000);
    chk({tag, "_cycles_to_e"}, n, PERIOD - 1);
  endtask

  initial begin
    int a, b, ne, k;
    duty = 7'd64;
    repeat (3) @(negedge clk);
    zero_outputs("reset");
    rstn = 1'b1;
    wait_e();
    window(a, b, ne, -1, duty, sw7);
    chk("d64_a", a, 128); chk("d64_b", b, 0); chk("d64_e_count", ne, 1); chk("d64_e_last", e, 1);
    duty = 7'd0;   window(a, b, ne, -1, duty, sw7); window(a, b, ne, -1, duty, sw7);
    chk("d0_a", a, 0);
    duty = 7'd127; window(a, b, ne, -1, duty, sw7); window(a, b, ne, -1, duty, sw7);
    chk("d127_a", a, 256);
    duty = 7'd100; window(a, b, ne, -1, duty, sw7); window(a, b, ne, -1, duty, sw7);
    chk("d100_a", a, 200);
    window(a, b, ne, 100, 7'd0, 1'b0);
    chk("midchange_a", a, 200);
    window(a, b, ne, -1, duty, sw7);
    chk("after_change_a", a, 0);
    duty = 7'd64;  window(a, b, ne, -1, duty, sw7);
    window(a, b, ne, 100, 7'd64, 1'b1);
    chk("rev_finish_a", a, 128); chk("rev_finish_b", b, 0);
    window(a, b, ne, -1, duty, sw7);
    chk("dead_a", a, 0); chk("dead_b", b, 0);
    window(a, b, ne, -1, duty, sw7);
    chk("rev_a", a, 0); chk("rev_b", b, 128);
    repeat (37) @(negedge clk);
    sns = 1'b1;
    repeat (3) @(negedge clk);
    sns = 1'b0;
    repeat (20) @(negedge clk);
    chk("pulse3_no_fault", oc, 0);
    sns = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!oc && k < 50);
    chk("oc_latency", k, OC_FILT + 2);
    chk("fault_legs", int'(pwm_a | pwm_b), 0);
    wait_e();
    window(a, b, ne, -1, duty, sw7);
    chk("fault_a", a, 0); chk("fault_b", b, 0); chk("fault_e_count", ne, 1);
    sns = 1'b0;
`ifdef OC_AUTO_RETRY_EN
    repeat (6) window(a, b, ne, -1, duty, sw7);
    chk("retry_oc", oc, 0);
    window(a, b, ne, -1, duty, sw7);
    chk("retry_b", b, 128);
`else
    repeat (3) window(a, b, ne, -1, duty, sw7);
    chk("sticky_oc", oc, 1);
    chk("sticky_b", b, 0);
`endif
    sns = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!oc && k < 50);
    chk("refault_oc", oc, 1);
    sns = 1'b0;
    repeat (37) @(negedge clk);
    reset_pulse_and_check("rst_fault");
    window(a, b, ne, -1, duty, sw7);
    chk("post_rst_dead_b", b, 0);
    window(a, b, ne, -1, duty, sw7);
    chk("post_rst_b", b, 128);
    repeat (100) @(negedge clk);
    reset_pulse_and_check("rst_run");
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end
endmodule
